muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide controller beside the execute-stage ALU. It accepts MULT/MULTU/DIV/DIVU issues with forwarded operands and runs a radix-2 shift-add or restoring-divide sequence. It owns the architectural HI/LO registers and stalls the pipeline when a later instruction needs the unit or its result before the sequence completes.

## Interface
- XLEN, 32: operand width; HI/LO width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- startE  in  1  issue pulse for a mul/div instruction in execute.
- opE  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcaE  in  XLEN  forwarded operand A (multiplicand / dividend).
- srcbE  in  XLEN  forwarded operand B (multiplier / divisor).
- readreqE  in  1  MFHI/MFLO present in execute.
- flushE  in  1  abort any in-flight operation.
- busy  out  1  sequence in progress.
- stallE  out  1  stall request to the hazard unit.
- done  out  1  one-cycle pulse; new HI/LO visible this cycle.
- divzero  out  1  one-cycle pulse coincident with done for a zero divisor.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, startE=1, flushE=0:
  - Latch op.
  - Latch operand magnitudes (signed ops: two's-complement abs; unsigned: raw).
  - Latch sign flags.
  - Load counter = XLEN-1.
  - Go to RUN, except DIV/DIVU with srcbE=0, which goes directly to FIX.
- RUN: one shift-add (multiply) or restore step (divide) per cycle; 64-bit accumulator. At counter 0 go to FIX, else decrement.
- FIX: apply signs, write HI/LO, pulse done, return to IDLE.
  - MULT: negate 64-bit product if signA^signB.
  - DIV: quotient negated if signA^signB; remainder takes sign of A.
  - lo = quotient or product[31:0]; hi = remainder or product[63:32].
- Divide by zero: hi = srcaE as latched, lo = 32'hFFFFFFFF, divzero=1.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- stallE = busy & (readreqE | startE).
- startE while busy: ignored. No relatch occurs, because the stall holds the instruction.
- flushE while busy: go to IDLE next edge, HI/LO unchanged, no done.
- flushE with startE in IDLE: start dropped.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, busy 0, stallE 0, done 0, divzero 0, hi 0, lo 0.
- Reset mid-operation: abort, all outputs return to reset values next edge.
- Start sampled at edge k:
  - busy high in cycles k+1 .. k+33 (32 RUN + 1 FIX).
  - done and new hi/lo in cycle k+34; busy low that cycle.
- Divide by zero: busy in cycle k+1 (FIX only); done, divzero and new hi/lo in cycle k+2.
- Back-to-back: a new start is accepted in the done cycle.
- hi/lo are registered outputs; they change only on the edge that ends FIX, or on reset.
- readreqE in the done cycle reads the new values with no stall.

## Structure
- Package muldiv_pkg holds:
  - XLEN
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum IDLE/RUN/FIX
- Sub-module muldiv_step: combinational single-iteration unit.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator.
- The FSM, counter, sign fixup and HI/LO registers stay in the top level.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 -> done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1–33.
- MULT -3 × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 10 / 0 -> done and divzero in cycle 2, hi=0x0000000A, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU 2×3, readreqE=1 from cycle 5 -> stallE=1 cycles 5–33, 0 at cycle 34 with lo=6. startE held during busy -> stallE=1, no relatch.
- Flush at cycle 10 of a DIV after prior hi=0x11, lo=0x22 -> busy=0 at cycle 11, no done, hi/lo still 0x11/0x22.
- rst=0 at cycle 15 of a MULT -> cycle 16: busy=0, hi=lo=0. A new start after rst returns to 1 completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;
    localparam int XLEN = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage connection between the pipeline and the mul/div sequencer.
interface muldiv_sequencer_if;
    import muldiv_pkg::*;

    // startE is an issue pulse with no ready: while busy, stallE holds the issuing
    // instruction in execute, so a startE seen during busy is ignored and re-presented.
    logic            startE;
    logic [1:0]      opE;
    logic [XLEN-1:0] srcaE;
    logic [XLEN-1:0] srcbE;
    logic            readreqE;
    logic            flushE;
    logic            busy;
    logic            stallE;
    logic            done;
    logic            divzero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    state_t          dbg_state;

    modport master (
        output startE, opE, srcaE, srcbE, readreqE, flushE,
        input  busy, stallE, done, divzero, hi, lo, dbg_state
    );

    modport slave (
        input  startE, opE, srcaE, srcbE, readreqE, flushE,
        output busy, stallE, done, divzero, hi, lo, dbg_state
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 64-bit accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_operand,
    input  logic              i_div,
    output logic [2*XLEN-1:0] o_acc
);
    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_operand};
        // Partial remainder after the left shift needs one extra bit before the compare.
        w_rem  = i_acc[2*XLEN-1:XLEN-1];
        w_diff = w_rem - {1'b0, i_operand};
        o_acc  = i_acc;
        if (i_div) begin
            if (!w_diff[XLEN]) begin
                o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {w_rem[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            end
        end else if (i_acc[0]) begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end else begin
            o_acc = {1'b0, i_acc[2*XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO, with pipeline stall generation.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_count;
    logic              r_is_div;
    logic              r_zero_div;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_done;
    logic              r_divzero;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_operand;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_start;
    logic              w_signed;
    logic              w_is_div;
    logic              w_zero_div;
    logic              w_busy;
    logic              w_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;

    assign w_start    = bus.startE & ~bus.flushE;
    assign w_signed   = (bus.opE == OP_MULT) || (bus.opE == OP_DIV);
    assign w_is_div   = (bus.opE == OP_DIV) || (bus.opE == OP_DIVU);
    assign w_zero_div = w_is_div && (bus.srcbE == '0);
    assign w_abs_a    = (w_signed && bus.srcaE[XLEN-1]) ? -bus.srcaE : bus.srcaE;
    assign w_abs_b    = (w_signed && bus.srcbE[XLEN-1]) ? -bus.srcbE : bus.srcbE;

    muldiv_step u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_div     (r_is_div),
        .o_acc     (w_step)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = w_zero_div ? FIX : RUN;
            RUN:     if (bus.flushE) w_next = IDLE;
                     else if (r_count == '0) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Zero-divisor ops keep |A| in the low half, so re-signing it restores srcaE.
    always_comb begin
        w_neg  = r_sign_a ^ r_sign_b;
        w_prod = w_neg ? -r_acc : r_acc;
        w_hi   = w_prod[2*XLEN-1:XLEN];
        w_lo   = w_prod[XLEN-1:0];
        if (r_zero_div) begin
            w_hi = r_sign_a ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
            w_lo = '1;
        end else if (r_is_div) begin
            w_hi = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
            w_lo = w_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_zero_div <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_done     <= 1'b0;
            r_divzero  <= 1'b0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                IDLE: if (w_start) begin
                    r_is_div   <= w_is_div;
                    r_zero_div <= w_zero_div;
                    r_sign_a   <= w_signed & bus.srcaE[XLEN-1];
                    r_sign_b   <= w_signed & bus.srcbE[XLEN-1];
                    r_count    <= CW'(XLEN-1);
                    r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    r_operand  <= w_is_div ? w_abs_b : w_abs_a;
                end
                RUN: begin
                    r_acc   <= w_step;
                    r_count <= r_count - CW'(1);
                end
                FIX: if (!bus.flushE) begin
                    r_hi      <= w_hi;
                    r_lo      <= w_lo;
                    r_done    <= 1'b1;
                    r_divzero <= r_zero_div;
                end
                default: ;
            endcase
        end
    end

    assign w_busy        = (r_state != IDLE);
    assign bus.busy      = w_busy;
    assign bus.stallE    = w_busy & (bus.readreqE | bus.startE);
    assign bus.done      = r_done;
    assign bus.divzero   = r_divzero;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model, per-cycle compare, directed corner cases.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Result is {divzero, hi, lo}, computed with plain 64-bit arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_MULT: begin
                q = sa * sb;
                return {1'b0, q[63:0]};
            end
            OP_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                return {1'b0, p};
            end
            OP_DIV: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    logic [64:0] exp_q[$];
    int          m_left;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_done;
    logic        m_dz;

    always @(posedge clk) begin
        logic [64:0] res;
        if (!rst) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
            m_dz   = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_left > 0) begin
                if (bus.flushE) begin
                    m_left = 0;
                    exp_q.delete();
                end else begin
                    m_left--;
                    if (m_left == 0 && exp_q.size() > 0) begin
                        res = exp_q.pop_front();
                        {m_dz, m_hi, m_lo} = res;
                        m_done = 1'b1;
                    end
                end
            end else if (bus.startE && !bus.flushE) begin
                res = ref_op(bus.opE, bus.srcaE, bus.srcbE);
                exp_q.push_back(res);
                m_left = res[64] ? 1 : 33;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    64'(bus.busy),    64'(m_left > 0));
            check("stallE",  64'(bus.stallE),  64'((m_left > 0) && (bus.readreqE || bus.startE)));
            check("done",    64'(bus.done),    64'(m_done));
            check("divzero", 64'(bus.divzero), 64'(m_dz));
            check("hi",      64'(bus.hi),      64'(m_hi));
            check("lo",      64'(bus.lo),      64'(m_lo));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.startE = 1'b1;
        bus.opE    = op;
        bus.srcaE  = a;
        bus.srcbE  = b;
        tick();
        bus.startE = 1'b0;
    endtask

    // Called in cycle 1 after the start edge; returns the cycle number in which done is seen.
    task automatic wait_done(output int c);
        c = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) return;
            tick();
            c++;
        end
    endtask

    task automatic run_lit(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dz, input int exp_cyc);
        int c;
        issue(op, a, b);
        wait_done(c);
        check({name, "_cycle"}, 64'(c), 64'(exp_cyc));
        check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({name, "_dz"}, 64'(bus.divzero), 64'(exp_dz));
        tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int c;
        int seen;
        int fl;
        bus.startE   = 1'b0;
        bus.opE      = OP_MULT;
        bus.srcaE    = '0;
        bus.srcbE    = '0;
        bus.readreqE = 1'b0;
        bus.flushE   = 1'b0;
        rst          = 1'b0;
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy",  64'(bus.busy),      64'(0));
        check("rst_hi",    64'(bus.hi),        64'(0));
        check("rst_lo",    64'(bus.lo),        64'(0));
        check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
        rst = 1'b1;
        tick();

        run_lit("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
        run_lit("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);
        run_lit("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
        run_lit("divu_zero", OP_DIVU,  32'd10,       32'd0,        32'h0000000A, 32'hFFFFFFFF, 1'b1, 2);
        run_lit("div_zero",  OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2);
        run_lit("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);

        // readreqE while busy stalls until the done cycle
        issue(OP_MULTU, 32'd2, 32'd3);
        repeat (4) tick();
        bus.readreqE = 1'b1;
        @(negedge clk);
        check("stall_c5", 64'(bus.stallE), 64'(1));
        repeat (28) tick();
        @(negedge clk);
        check("stall_c33", 64'(bus.stallE), 64'(1));
        tick();
        @(negedge clk);
        check("stall_c34", 64'(bus.stallE), 64'(0));
        check("stall_done", 64'(bus.done), 64'(1));
        check("stall_lo", 64'(bus.lo), 64'(6));
        tick();
        bus.readreqE = 1'b0;

        // startE held through busy: ignored, then accepted back-to-back in the done cycle
        issue(OP_MULTU, 32'd100, 32'd200);
        bus.startE = 1'b1;
        bus.opE    = OP_DIVU;
        bus.srcaE  = 32'd1000;
        bus.srcbE  = 32'd7;
        wait_done(c);
        check("held_cycle", 64'(c), 64'(34));
        check("held_lo", 64'(bus.lo), 64'(20000));
        check("held_hi", 64'(bus.hi), 64'(0));
        tick();
        bus.startE = 1'b0;
        wait_done(c);
        check("b2b_cycle", 64'(c), 64'(34));
        check("b2b_lo", 64'(bus.lo), 64'(142));
        check("b2b_hi", 64'(bus.hi), 64'(6));
        tick();

        // flush mid-divide leaves HI/LO untouched
        run_lit("prep", OP_DIVU, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34);
        issue(OP_DIV, 32'd12345, 32'd67);
        repeat (9) tick();
        bus.flushE = 1'b1;
        tick();
        bus.flushE = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(bus.busy), 64'(0));
        check("flush_hi", 64'(bus.hi), 64'h11);
        check("flush_lo", 64'(bus.lo), 64'h22);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("flush_nodone", 64'(seen), 64'(0));
        tick();

        // start together with flush in IDLE is dropped
        bus.startE = 1'b1;
        bus.flushE = 1'b1;
        tick();
        bus.startE = 1'b0;
        bus.flushE = 1'b0;
        @(negedge clk);
        check("flush_start", 64'(bus.busy), 64'(0));
        tick();

        // reset mid-multiply
        issue(OP_MULT, 32'h1234, 32'h5678);
        repeat (14) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_hi", 64'(bus.hi), 64'(0));
        check("mid_rst_lo", 64'(bus.lo), 64'(0));
        tick();
        run_lit("post_rst", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);

        // randomized operations, checked every cycle by the scoreboard
        for (int n = 0; n < 60; n++) begin
            bus.readreqE = 1'($urandom_range(0, 1));
            issue(2'($urandom_range(0, 3)), pick(), pick());
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 33)) : 0;
            for (int i = 1; i <= 40; i++) begin
                bus.readreqE = 1'($urandom_range(0, 1));
                bus.flushE   = (i == fl);
                @(negedge clk);
                if (!bus.busy) break;
                tick();
            end
            bus.flushE = 1'b0;
            check("rnd_idle", 64'(bus.busy), 64'(0));
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end
        bus.readreqE = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
